mem_slot_arbiter: RTL and testbench

- Time-slot arbiter sharing one single-port synchronous RAM between the video fetcher and the Z80 CPU.
- Sits between the CPU bus decode / video address generator and the RAM.
- Runs a 4-slot frame advanced by a slot strobe (ce). Video has priority in even slots, CPU in odd slots; a slot not claimed by its owner goes to the other requester.
- Returns read data with fixed latency and one-clock ack/valid pulses.

---
 rtl/mem_slot_arbiter_pkg.sv | 25 ++
 rtl/mem_slot_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_slot_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_slot_arbiter_pkg.sv
// Shared definitions for the RAM slot arbiter: owner encoding, frame length, slot priority.
// Define MEM_SLOT_ARB_VBLANK_CPU_EN to give the CPU first pick of every slot during vblank.
package mem_slot_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   localparam int unsigned SLOTS  = 4;
   localparam int unsigned SLOT_W = $clog2(SLOTS);

`ifdef MEM_SLOT_ARB_VBLANK_CPU_EN
   localparam bit VBLANK_CPU_EN = 1'b1;
`else
   localparam bit VBLANK_CPU_EN = 1'b0;
`endif

   // Odd slots belong to the CPU; optionally every slot does while the beam is blanked.
   function automatic logic cpu_first(input logic [SLOT_W-1:0] slot, input logic vblank);
      return slot[0] | (VBLANK_CPU_EN & vblank);
   endfunction

endpackage

// File: rtl/mem_slot_arbiter.sv
// Shares one single-port synchronous RAM between video fetches and Z80 accesses in a 4-slot
// frame. Optional vblank CPU priority is enabled by MEM_SLOT_ARB_VBLANK_CPU_EN.
module mem_slot_arbiter
   import mem_slot_arbiter_pkg::*;
#(
   parameter int unsigned AW    = 16,
   parameter int unsigned RDLAT = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ce,
   input  logic          vblank,
   input  logic          vidReq,
   input  logic [AW-1:0] vidA,
   output logic [7:0]    vidQ,
   output logic          vidValid,
   output logic          vidOvr,
   input  logic          cpuReq,
   input  logic          cpuWe,
   input  logic [AW-1:0] cpuA,
   input  logic [7:0]    cpuD,
   output logic [7:0]    cpuQ,
   output logic          cpuAck,
   output logic [AW-1:0] ramA,
   output logic [7:0]    ramD,
   output logic          ramWe,
   input  logic [7:0]    ramQ
);

   typedef struct packed {
      owner_t owner;
      logic   we;
   } pipe_t;

   logic [SLOT_W-1:0] slot_q;
   logic              vid_pend_q;
   logic [AW-1:0]     vid_addr_q;
   logic              cpu_served_q;
   pipe_t             pipe_q [RDLAT+1];

   logic   cpu_pend;
   owner_t grant;

   always_comb begin
      cpu_pend = cpuReq & ~cpu_served_q;
      grant    = OWN_NONE;
      if (ce) begin
         if (cpu_first(slot_q, vblank)) begin
            if (cpu_pend)        grant = OWN_CPU;
            else if (vid_pend_q) grant = OWN_VID;
         end else begin
            if (vid_pend_q)      grant = OWN_VID;
            else if (cpu_pend)   grant = OWN_CPU;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_q       <= '0;
         vid_pend_q   <= 1'b0;
         vid_addr_q   <= '0;
         cpu_served_q <= 1'b0;
         for (int i = 0; i <= RDLAT; i++) pipe_q[i] <= '{owner: OWN_NONE, we: 1'b0};
         ramA         <= '0;
         ramD         <= '0;
         ramWe        <= 1'b0;
         vidQ         <= '0;
         vidValid     <= 1'b0;
         vidOvr       <= 1'b0;
         cpuQ         <= '0;
         cpuAck       <= 1'b0;
      end else begin
         ramWe    <= 1'b0;
         vidValid <= 1'b0;
         vidOvr   <= 1'b0;
         cpuAck   <= 1'b0;

         // SLOTS is a power of two, so the natural wrap gives the mod-4 frame.
         if (ce) slot_q <= slot_q + SLOT_W'(1);

         case (grant)
            OWN_VID: ramA <= vid_addr_q;
            OWN_CPU: begin
               ramA  <= cpuA;
               ramD  <= cpuD;
               ramWe <= cpuWe;
            end
            default: ;
         endcase

         // A request landing on the grant edge of the old one queues behind it, no overrun.
         if (vidReq) begin
            vid_pend_q <= 1'b1;
            vid_addr_q <= vidA;
            vidOvr     <= vid_pend_q & (grant != OWN_VID);
         end else if (grant == OWN_VID) begin
            vid_pend_q <= 1'b0;
         end

         if (!cpuReq)              cpu_served_q <= 1'b0;
         else if (grant == OWN_CPU) cpu_served_q <= 1'b1;

         pipe_q[0] <= '{owner: grant, we: (grant == OWN_CPU) & cpuWe};
         for (int i = 1; i <= RDLAT; i++) pipe_q[i] <= pipe_q[i-1];

         case (pipe_q[RDLAT].owner)
            OWN_VID: begin
               vidQ     <= ramQ;
               vidValid <= 1'b1;
            end
            OWN_CPU: begin
               cpuAck <= 1'b1;
               if (!pipe_q[RDLAT].we) cpuQ <= ramQ;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Self-checking bench for mem_slot_arbiter: directed scenarios plus a randomized run against
// a transaction-level reference model and a behavioural synchronous RAM.
module tb_mem_slot_arbiter;

   localparam int unsigned AW    = 16;
   localparam int unsigned RDLAT = 1;
`ifdef MEM_SLOT_ARB_VBLANK_CPU_EN
   localparam bit VB_EN = 1'b1;
`else
   localparam bit VB_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset, ce, vblank, vidReq, cpuReq, cpuWe;
   logic [AW-1:0] vidA, cpuA, ramA;
   logic [7:0]    cpuD, vidQ, cpuQ, ramD, ramQ;
   logic          vidValid, vidOvr, cpuAck, ramWe;

   int checks   = 0;
   int failures = 0;

   mem_slot_arbiter #(.AW(AW), .RDLAT(RDLAT)) dut (
      .clock    (clock),
      .reset    (reset),
      .ce       (ce),
      .vblank   (vblank),
      .vidReq   (vidReq),
      .vidA     (vidA),
      .vidQ     (vidQ),
      .vidValid (vidValid),
      .vidOvr   (vidOvr),
      .cpuReq   (cpuReq),
      .cpuWe    (cpuWe),
      .cpuA     (cpuA),
      .cpuD     (cpuD),
      .cpuQ     (cpuQ),
      .cpuAck   (cpuAck),
      .ramA     (ramA),
      .ramD     (ramD),
      .ramWe    (ramWe),
      .ramQ     (ramQ)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // Behavioural RAM, one clock read latency; unwritten locations read as pat(addr).
   logic [7:0] tb_mem [65536];
   bit         tb_wr  [65536];
   always @(posedge clock) begin
      ramQ <= tb_wr[ramA] ? tb_mem[ramA] : pat(ramA);
      if (ramWe) begin
         tb_mem[ramA] <= ramD;
         tb_wr[ramA]  <= 1'b1;
      end
   end

   // Reference model state.
   typedef struct {
      int         due;
      int         own;  // 1 = video, 2 = cpu
      bit         we;
      logic [7:0] data;
   } comp_t;

   logic [7:0] ref_mem [65536];
   bit         ref_wr  [65536];
   int         cyc = 0;
   int         m_slot = 0;
   bit         m_vid_pend = 0;
   logic [15:0] m_vid_addr = '0;
   bit         m_cpu_served = 0;
   comp_t      m_q [$];
   logic [15:0] e_ramA = '0;
   logic [7:0]  e_ramD = '0, e_vidQ = '0, e_cpuQ = '0;
   logic        e_ramWe = 0, e_vidValid = 0, e_vidOvr = 0, e_cpuAck = 0;

   function automatic logic [7:0] ref_rd(input logic [15:0] a);
      return ref_wr[a] ? ref_mem[a] : pat(a);
   endfunction

   // Advance the model by one clock edge using the inputs as currently driven.
   task automatic model_edge();
      bit    gv, gc, cpu_pend, cpu_pri;
      comp_t c;
      cyc++;
      e_ramWe = 0; e_vidValid = 0; e_vidOvr = 0; e_cpuAck = 0;
      if (reset) begin
         m_slot = 0; m_vid_pend = 0; m_cpu_served = 0; m_q.delete();
         e_ramA = '0; e_ramD = '0; e_vidQ = '0; e_cpuQ = '0;
         return;
      end
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
         c = m_q.pop_front();
         if (c.own == 1) begin
            e_vidValid = 1; e_vidQ = c.data;
         end else begin
            e_cpuAck = 1;
            if (!c.we) e_cpuQ = c.data;
         end
      end
      gv = 0; gc = 0;
      if (ce) begin
         cpu_pend = cpuReq && !m_cpu_served;
         cpu_pri  = (m_slot % 2 == 1) || (VB_EN && vblank);
         if (cpu_pri) begin
            if (cpu_pend) gc = 1; else if (m_vid_pend) gv = 1;
         end else begin
            if (m_vid_pend) gv = 1; else if (cpu_pend) gc = 1;
         end
         m_slot = (m_slot + 1) % 4;
      end
      if (gv) begin
         e_ramA = m_vid_addr;
         m_q.push_back('{due: cyc + RDLAT + 1, own: 1, we: 0, data: ref_rd(m_vid_addr)});
      end
      if (gc) begin
         e_ramA = cpuA; e_ramD = cpuD; e_ramWe = cpuWe;
         m_q.push_back('{due: cyc + RDLAT + 1, own: 2, we: cpuWe, data: ref_rd(cpuA)});
         if (cpuWe) begin
            ref_mem[cpuA] = cpuD; ref_wr[cpuA] = 1;
         end
      end
      if (vidReq) begin
         if (m_vid_pend && !gv) e_vidOvr = 1;
         m_vid_pend = 1; m_vid_addr = vidA;
      end else if (gv) begin
         m_vid_pend = 0;
      end
      if (!cpuReq) m_cpu_served = 0;
      else if (gc) m_cpu_served = 1;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      ce = 0; vblank = 0; vidReq = 0; cpuReq = 0; cpuWe = 0;
      vidA = '0; cpuA = '0; cpuD = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      int acks;
      idle_inputs();
      reset = 1;
      tick(); tick();
      checks++;
      if ({ramA, ramD, ramWe, vidQ, vidValid, vidOvr, cpuQ, cpuAck} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got ramA=%h ramD=%h ramWe=%b vidQ=%h vidValid=%b vidOvr=%b cpuQ=%h cpuAck=%b, want all 0",
                  ramA, ramD, ramWe, vidQ, vidValid, vidOvr, cpuQ, cpuAck);
      end
      reset = 0; cpuReq = 1; cpuWe = 0; cpuA = 16'h5123; ce = 1;
      tick();
      checks++;
      if (ramA !== 16'h5123) begin
         failures++; $display("FAIL reset_pre_grant: ramA=%h want 5123", ramA);
      end
      reset = 1; ce = 0;
      tick();
      checks++;
      if ({ramA, ramD, ramWe, vidQ, vidValid, vidOvr, cpuQ, cpuAck} !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs: got ramA=%h ramWe=%b cpuAck=%b vidValid=%b, want all 0",
                  ramA, ramWe, cpuAck, vidValid);
      end
      reset = 0; cpuReq = 0;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cpuAck) acks++;
      end
      checks++;
      if (acks != 0) begin
         failures++; $display("FAIL reset_discard_ack: cpuAck pulses=%0d want 0", acks);
      end
      // Slot counter must be back at 0: the even slot goes to video.
      vidReq = 1; vidA = 16'h4400;
      tick();
      vidReq = 0; cpuReq = 1; cpuA = 16'h5000; ce = 1;
      tick();
      checks++;
      if (ramA !== 16'h4400) begin
         failures++; $display("FAIL reset_slot0: ramA=%h want 4400", ramA);
      end
   endtask

   task automatic test_priority();
      do_reset();
      vidReq = 1; vidA = 16'h4400; cpuReq = 1; cpuWe = 0; cpuA = 16'h5000;
      tick();
      vidReq = 0; ce = 1;
      tick();  // slot 0 edge
      checks++;
      if (ramA !== 16'h4400 || ramWe !== 1'b0) begin
         failures++; $display("FAIL prio_slot0: ramA=%h ramWe=%b want 4400/0", ramA, ramWe);
      end
      tick();  // slot 1 edge
      checks++;
      if (ramA !== 16'h5000 || vidValid !== 1'b0) begin
         failures++; $display("FAIL prio_slot1: ramA=%h vidValid=%b want 5000/0", ramA, vidValid);
      end
      ce = 0;
      tick();
      checks++;
      if (vidValid !== 1'b1 || vidQ !== pat(16'h4400) || cpuAck !== 1'b0) begin
         failures++;
         $display("FAIL prio_vid_valid: vidValid=%b vidQ=%h cpuAck=%b want 1/%h/0",
                  vidValid, vidQ, cpuAck, pat(16'h4400));
      end
      tick();
      checks++;
      if (cpuAck !== 1'b1 || cpuQ !== pat(16'h5000) || vidValid !== 1'b0) begin
         failures++;
         $display("FAIL prio_cpu_ack: cpuAck=%b cpuQ=%h vidValid=%b want 1/%h/0",
                  cpuAck, cpuQ, vidValid, pat(16'h5000));
      end
   endtask

   task automatic test_cpu_write();
      int we_high, acks;
      bit got;
      do_reset();
      ce = 1;
      tick();  // idle slot 0
      cpuReq = 1; cpuWe = 1; cpuA = 16'h4000; cpuD = 8'hA5;
      tick();  // odd slot 1
      checks++;
      if (ramWe !== 1'b1 || ramA !== 16'h4000 || ramD !== 8'hA5) begin
         failures++; $display("FAIL wr_issue: ramWe=%b ramA=%h ramD=%h want 1/4000/a5", ramWe, ramA, ramD);
      end
      we_high = 1; acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (ramWe) we_high++;
         if (cpuAck) acks++;
      end
      checks++;
      if (we_high != 1) begin
         failures++; $display("FAIL wr_we_width: ramWe high clocks=%0d want 1", we_high);
      end
      checks++;
      if (acks != 1) begin
         failures++; $display("FAIL wr_ack_count: cpuAck pulses=%0d want 1", acks);
      end
      cpuReq = 0;
      tick();
      cpuReq = 1; cpuWe = 0;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (cpuAck) got = 1;
      end
      checks++;
      if (!got || cpuQ !== 8'hA5) begin
         failures++; $display("FAIL wr_readback: acked=%0d cpuQ=%h want 1/a5", got, cpuQ);
      end
      cpuReq = 0;
   endtask

   task automatic test_cpu_hold();
      int acks;
      do_reset();
      cpuReq = 1; cpuWe = 0; cpuA = 16'h4123; ce = 1;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cpuAck) acks++;
      end
      ce = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (cpuAck) acks++;
      end
      checks++;
      if (acks != 1 || cpuQ !== pat(16'h4123)) begin
         failures++;
         $display("FAIL hold_single: acks=%0d cpuQ=%h want 1/%h", acks, cpuQ, pat(16'h4123));
      end
      cpuReq = 0;
      tick();
      cpuReq = 1; cpuA = 16'h4124; ce = 1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (cpuAck) acks++;
      end
      checks++;
      if (acks != 1 || cpuQ !== pat(16'h4124)) begin
         failures++;
         $display("FAIL hold_second: acks=%0d cpuQ=%h want 1/%h", acks, cpuQ, pat(16'h4124));
      end
      cpuReq = 0; ce = 0;
   endtask

   task automatic test_vid_overwrite();
      int valids;
      do_reset();
      vidReq = 1; vidA = 16'h4400;
      tick();
      checks++;
      if (vidOvr !== 1'b0) begin
         failures++; $display("FAIL ovr_first: vidOvr=%b want 0", vidOvr);
      end
      vidA = 16'h4401;
      tick();
      checks++;
      if (vidOvr !== 1'b1) begin
         failures++; $display("FAIL ovr_pulse: vidOvr=%b want 1", vidOvr);
      end
      vidReq = 0;
      tick();
      checks++;
      if (vidOvr !== 1'b0) begin
         failures++; $display("FAIL ovr_one_clock: vidOvr=%b want 0", vidOvr);
      end
      ce = 1;
      tick();
      checks++;
      if (ramA !== 16'h4401) begin
         failures++; $display("FAIL ovr_fetch_addr: ramA=%h want 4401", ramA);
      end
      ce = 0;
      valids = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (vidValid) valids++;
      end
      checks++;
      if (valids != 1 || vidQ !== pat(16'h4401)) begin
         failures++;
         $display("FAIL ovr_single_valid: valids=%0d vidQ=%h want 1/%h", valids, vidQ, pat(16'h4401));
      end
      // New request on the grant edge of the pending one: old address wins, no overrun.
      vidReq = 1; vidA = 16'h4410;
      tick();
      vidA = 16'h4411; ce = 1;
      tick();
      checks++;
      if (ramA !== 16'h4410 || vidOvr !== 1'b0) begin
         failures++; $display("FAIL ovr_coincide: ramA=%h vidOvr=%b want 4410/0", ramA, vidOvr);
      end
      vidReq = 0;
      tick();
      checks++;
      if (ramA !== 16'h4411) begin
         failures++; $display("FAIL ovr_coincide_next: ramA=%h want 4411", ramA);
      end
      ce = 0;
   endtask

   task automatic test_vblank();
      logic [15:0] want;
      do_reset();
      vblank = 1; vidReq = 1; vidA = 16'h4400;
      tick();
      vidReq = 0; cpuReq = 1; cpuWe = 0; cpuA = 16'h5000; ce = 1;
      tick();
      want = VB_EN ? 16'h5000 : 16'h4400;
      checks++;
      if (ramA !== want) begin
         failures++; $display("FAIL vblank_slot0: ramA=%h want %h", ramA, want);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         reset  = ($urandom_range(199) == 0);
         ce     = 1'($urandom_range(1));
         vblank = ($urandom_range(7) == 0);
         vidReq = ($urandom_range(4) == 0);
         vidA   = 16'h4000 | 16'($urandom_range(63));
         if (cpuReq) begin
            if ($urandom_range(9) == 0) cpuReq = 0;
         end else begin
            cpuWe  = 1'($urandom_range(1));
            cpuA   = 16'h4000 | 16'($urandom_range(63));
            cpuD   = 8'($urandom);
            cpuReq = ($urandom_range(2) == 0);
         end
         tick();
         checks++;
         if (ramA !== e_ramA) begin
            failures++; $display("FAIL rnd_ramA cyc=%0d: got %h want %h", n, ramA, e_ramA);
         end
         checks++;
         if (ramWe !== e_ramWe) begin
            failures++; $display("FAIL rnd_ramWe cyc=%0d: got %b want %b", n, ramWe, e_ramWe);
         end
         checks++;
         if (ramD !== e_ramD) begin
            failures++; $display("FAIL rnd_ramD cyc=%0d: got %h want %h", n, ramD, e_ramD);
         end
         checks++;
         if (vidValid !== e_vidValid) begin
            failures++; $display("FAIL rnd_vidValid cyc=%0d: got %b want %b", n, vidValid, e_vidValid);
         end
         checks++;
         if (vidQ !== e_vidQ) begin
            failures++; $display("FAIL rnd_vidQ cyc=%0d: got %h want %h", n, vidQ, e_vidQ);
         end
         checks++;
         if (vidOvr !== e_vidOvr) begin
            failures++; $display("FAIL rnd_vidOvr cyc=%0d: got %b want %b", n, vidOvr, e_vidOvr);
         end
         checks++;
         if (cpuAck !== e_cpuAck) begin
            failures++; $display("FAIL rnd_cpuAck cyc=%0d: got %b want %b", n, cpuAck, e_cpuAck);
         end
         checks++;
         if (cpuQ !== e_cpuQ) begin
            failures++; $display("FAIL rnd_cpuQ cyc=%0d: got %h want %h", n, cpuQ, e_cpuQ);
         end
      end
      idle_inputs();
      reset = 0;
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_priority();
      test_cpu_write();
      test_cpu_hold();
      test_vid_overwrite();
      test_vblank();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
